// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch
//
// Instruction fetch unit. Issues one instruction-memory read at a time from
// the internal PC and holds the returned 32-bit word (with its PC and a fault
// flag) until the decoder accepts it. The PC is steered by reset, sequential
// +4 after each consumed instruction, redirects (jal/jalr/taken branch) and a
// permanent halt (ebreak) that only reset clears.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   redirect_valid/_pc  replace the PC with redirect_pc on the next edge
//   halt                stop fetching until reset
//   imem_req_*          read request channel (valid/ready, 64-bit address)
//   imem_resp_*         read response (valid, 32-bit data, access error)
//   inst_valid/_ready   handshake towards the decoder
//   inst, inst_pc       fetched word and the PC it was fetched from
//   inst_fault          misaligned PC or memory access error
//
// Priority in every state: halt > redirect > normal progress.
// ---------------------------------------------------------------------------
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        inst_fault
);

  typedef enum logic [2:0] {
    S_REQ    = 3'd0,
    S_WAIT   = 3'd1,
    S_DRAIN  = 3'd2,
    S_HOLD   = 3'd3,
    S_HALTED = 3'd4
  } state_e;

  state_e      state_q;
  logic [63:0] pc_q;
  logic        drain_halt_q;  // halt arrived while a response is still owed
  logic        inst_valid_q;
  logic [31:0] inst_q;
  logic [63:0] inst_pc_q;
  logic        inst_fault_q;

  logic [63:0] pc_seq_d;
  logic        pc_misaligned;

  function automatic logic is_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

  // Sequential PC wraps naturally modulo 2^64.
  function automatic logic [63:0] next_seq_pc(input logic [63:0] pc);
    return pc + 64'd4;
  endfunction

  assign pc_seq_d      = next_seq_pc(pc_q);
  assign pc_misaligned = is_misaligned(pc_q[1:0]);

  // The request is suppressed combinationally in a halt or redirect cycle so
  // that a fetch from the stale PC is never accepted.
  assign imem_req_valid = (state_q == S_REQ) & ~redirect_valid & ~halt & ~pc_misaligned;
  assign imem_req_addr  = pc_q;

  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_fault = inst_fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      drain_halt_q <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_fault_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (halt) begin
            state_q <= S_HALTED;
          end else if (redirect_valid) begin
            pc_q <= redirect_pc;
          end else if (pc_misaligned) begin
            // Misaligned PC: report a fault without touching memory.
            inst_q       <= '0;
            inst_pc_q    <= pc_q;
            inst_fault_q <= 1'b1;
            inst_valid_q <= 1'b1;
            state_q      <= S_HOLD;
          end else if (imem_req_ready) begin
            state_q <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (halt) begin
            // A response arriving with the halt settles the debt at once;
            // otherwise it must still be drained before going quiet.
            if (imem_resp_valid) begin
              state_q <= S_HALTED;
            end else begin
              drain_halt_q <= 1'b1;
              state_q      <= S_DRAIN;
            end
          end else if (redirect_valid) begin
            pc_q    <= redirect_pc;
            state_q <= imem_resp_valid ? S_REQ : S_DRAIN;
          end else if (imem_resp_valid) begin
            inst_q       <= imem_resp_data;
            inst_pc_q    <= pc_q;
            inst_fault_q <= imem_resp_err;
            inst_valid_q <= 1'b1;
            state_q      <= S_HOLD;
          end
        end

        S_DRAIN: begin
          if (imem_resp_valid) begin
            drain_halt_q <= 1'b0;
            if (halt || drain_halt_q) begin
              state_q <= S_HALTED;
            end else begin
              if (redirect_valid) begin
                pc_q <= redirect_pc;
              end
              state_q <= S_REQ;
            end
          end else if (halt || drain_halt_q) begin
            drain_halt_q <= 1'b1;
          end else if (redirect_valid) begin
            pc_q <= redirect_pc;
          end
        end

        S_HOLD: begin
          if (halt) begin
            inst_valid_q <= 1'b0;
            state_q      <= S_HALTED;
          end else if (redirect_valid) begin
            inst_valid_q <= 1'b0;
            pc_q         <= redirect_pc;
            state_q      <= S_REQ;
          end else if (inst_ready) begin
            inst_valid_q <= 1'b0;
            pc_q         <= pc_seq_d;
            state_q      <= S_REQ;
          end
        end

        S_HALTED: begin
          inst_valid_q <= 1'b0;
        end

        default: begin
          // Unreachable encodings recover to a clean fetch.
          inst_valid_q <= 1'b0;
          drain_halt_q <= 1'b0;
          state_q      <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_fault;

  int n_checks = 0;
  int n_fail   = 0;

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halt            (halt),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_fault      (inst_fault)
  );

  always #5 clk = ~clk;

  // Memory image used by the randomized run: content derived from the address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0F1E_2D3C;
  endfunction

  function automatic logic mem_err(input logic [3:0] a_5_2);
    return a_5_2 == 4'hB;
  endfunction

  function automatic logic [63:0] rnd_target();
    logic [63:0] t;
    if ($urandom_range(0, 15) == 0) t = 64'hFFFF_FFFF_FFFF_FFF8;
    else t = RESET_PC + 64'({$urandom_range(0, 255), 2'b00});
    if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    halt            = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    imem_resp_err   = 1'b0;
    inst_ready      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %0b want 0", inst_valid); end
    n_checks++; if (inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", inst); end
    n_checks++; if (inst_pc !== 64'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
    n_checks++; if (inst_fault !== 1'b0) begin n_fail++; $display("FAIL reset_inst_fault: got %0b want 0", inst_fault); end
    n_checks++; if (imem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_addr: got %h want %h", imem_req_addr, RESET_PC); end
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_basic_fetch();
    step(); imem_req_ready = 1'b1; smp();
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL basic_req_valid: got %0b want 1", imem_req_valid); end
    n_checks++; if (imem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL basic_req_addr: got %h want %h", imem_req_addr, RESET_PC); end
    step(); imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0010_0093; smp();
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL basic_wait_req: got %0b want 0", imem_req_valid); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL basic_wait_valid: got %0b want 0", inst_valid); end
    step(); imem_resp_valid = 1'b0; inst_ready = 1'b1; smp();
    n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL basic_inst_valid: got %0b want 1", inst_valid); end
    n_checks++; if (inst !== 32'h0010_0093) begin n_fail++; $display("FAIL basic_inst: got %h want 00100093", inst); end
    n_checks++; if (inst_pc !== RESET_PC) begin n_fail++; $display("FAIL basic_inst_pc: got %h want %h", inst_pc, RESET_PC); end
    n_checks++; if (inst_fault !== 1'b0) begin n_fail++; $display("FAIL basic_fault: got %0b want 0", inst_fault); end
    step(); inst_ready = 1'b0; imem_req_ready = 1'b1; smp();
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL basic_next_req: got %0b want 1", imem_req_valid); end
    n_checks++; if (imem_req_addr !== 64'h8000_0004) begin n_fail++; $display("FAIL basic_next_addr: got %h want 80000004", imem_req_addr); end
  endtask

  task automatic test_hold_stall();
    step(); imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0040_0113; smp();
    step(); imem_resp_valid = 1'b0; inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      smp();
      n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %0b want 1", i, inst_valid); end
      n_checks++; if (inst !== 32'h0040_0113) begin n_fail++; $display("FAIL hold_inst[%0d]: got %h want 00400113", i, inst); end
      n_checks++; if (inst_pc !== 64'h8000_0004) begin n_fail++; $display("FAIL hold_pc[%0d]: got %h want 80000004", i, inst_pc); end
      n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL hold_req[%0d]: got %0b want 0", i, imem_req_valid); end
    end
    step(); inst_ready = 1'b1; smp();
    step(); inst_ready = 1'b0; smp();
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL hold_next_req: got %0b want 1", imem_req_valid); end
    n_checks++; if (imem_req_addr !== 64'h8000_0008) begin n_fail++; $display("FAIL hold_next_addr: got %h want 80000008", imem_req_addr); end
  endtask

  task automatic test_redirect_wait();
    step(); imem_req_ready = 1'b1; smp();
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL redir_req: got %0b want 1", imem_req_valid); end
    step(); imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_0100; smp();
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_cycle_req: got %0b want 0", imem_req_valid); end
    step(); redirect_valid = 1'b0; smp();
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_drain_req: got %0b want 0", imem_req_valid); end
    n_checks++; if (imem_req_addr !== 64'h8000_0100) begin n_fail++; $display("FAIL redir_drain_addr: got %h want 80000100", imem_req_addr); end
    step(); imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF; smp();
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_resp_req: got %0b want 0", imem_req_valid); end
    step(); imem_resp_valid = 1'b0; imem_req_ready = 1'b1; smp();
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL redir_new_req: got %0b want 1", imem_req_valid); end
    n_checks++; if (imem_req_addr !== 64'h8000_0100) begin n_fail++; $display("FAIL redir_new_addr: got %h want 80000100", imem_req_addr); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_stale_valid: got %0b want 0", inst_valid); end
    step(); imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h1234_5678; smp();
    step(); imem_resp_valid = 1'b0; inst_ready = 1'b1; smp();
    n_checks++; if (inst !== 32'h1234_5678) begin n_fail++; $display("FAIL redir_inst: got %h want 12345678", inst); end
    n_checks++; if (inst_pc !== 64'h8000_0100) begin n_fail++; $display("FAIL redir_inst_pc: got %h want 80000100", inst_pc); end
    step(); inst_ready = 1'b0; smp();
  endtask

  task automatic test_misaligned();
    step(); redirect_valid = 1'b1; redirect_pc = 64'h8000_0102; imem_req_ready = 1'b1; smp();
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mis_redir_req: got %0b want 0", imem_req_valid); end
    step(); redirect_valid = 1'b0; smp();
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mis_no_req: got %0b want 0", imem_req_valid); end
    step(); smp();
    n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL mis_valid: got %0b want 1", inst_valid); end
    n_checks++; if (inst !== 32'h0) begin n_fail++; $display("FAIL mis_inst: got %h want 0", inst); end
    n_checks++; if (inst_pc !== 64'h8000_0102) begin n_fail++; $display("FAIL mis_pc: got %h want 80000102", inst_pc); end
    n_checks++; if (inst_fault !== 1'b1) begin n_fail++; $display("FAIL mis_fault: got %0b want 1", inst_fault); end
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mis_hold_req: got %0b want 0", imem_req_valid); end
    step(); redirect_valid = 1'b1; redirect_pc = 64'h8000_0200; smp();
    step(); redirect_valid = 1'b0; smp();
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL mis_drop_valid: got %0b want 0", inst_valid); end
    n_checks++; if (imem_req_addr !== 64'h8000_0200 || imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL mis_realign_req: got %0b/%h want 1/80000200", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_resp_err();
    step(); imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0; imem_resp_err = 1'b1; smp();
    step(); imem_resp_valid = 1'b0; imem_resp_err = 1'b0; smp();
    n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL err_valid: got %0b want 1", inst_valid); end
    n_checks++; if (inst_fault !== 1'b1) begin n_fail++; $display("FAIL err_fault: got %0b want 1", inst_fault); end
    n_checks++; if (inst_pc !== 64'h8000_0200) begin n_fail++; $display("FAIL err_pc: got %h want 80000200", inst_pc); end
    step(); inst_ready = 1'b1; smp();
    step(); inst_ready = 1'b0; smp();
  endtask

  task automatic test_halt_reset();
    step(); imem_req_ready = 1'b1; smp();
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0204) begin n_fail++; $display("FAIL halt_pre_req: got %0b/%h want 1/80000204", imem_req_valid, imem_req_addr); end
    step(); imem_req_ready = 1'b0; halt = 1'b1; smp();
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL halt_cycle_req: got %0b want 0", imem_req_valid); end
    step(); halt = 1'b0; imem_req_ready = 1'b1; smp();
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL halt_drain_req: got %0b want 0", imem_req_valid); end
    step(); imem_resp_valid = 1'b1; imem_resp_data = 32'hCAFE_0001; smp();
    step(); imem_resp_valid = 1'b0; inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      smp();
      n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL halted_req[%0d]: got %0b want 0", i, imem_req_valid); end
      n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL halted_valid[%0d]: got %0b want 0", i, inst_valid); end
    end
    step(); #2; rst_n = 1'b0; #1;
    n_checks++; if (inst_pc !== 64'h0) begin n_fail++; $display("FAIL async_inst_pc: got %h want 0", inst_pc); end
    n_checks++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_fault !== 1'b0) begin n_fail++; $display("FAIL async_outputs: got %0b/%h/%0b want 0/0/0", inst_valid, inst, inst_fault); end
    n_checks++; if (imem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL async_addr: got %h want %h", imem_req_addr, RESET_PC); end
    idle_inputs();
    step(); step(); rst_n = 1'b1; smp();
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL post_reset_req: got %0b/%h want 1/%h", imem_req_valid, imem_req_addr, RESET_PC); end
  endtask

  // Reference: the next instruction handed to the decoder must come from the
  // architectural PC (reset, +4 per consumed instruction, redirect target),
  // carry the memory image's word/error (or a fault if misaligned), and no
  // request may be made after halt or while a response is still owed.
  task automatic test_random();
    logic [63:0] exp_pc, pend_addr;
    logic        pend, halted_m, wd_ok;
    int          pend_cnt, idle, deliv, halt_cyc;
    for (int ep = 0; ep < 4; ep++) begin
      do_reset();
      exp_pc = RESET_PC; pend_addr = '0; pend = 1'b0; pend_cnt = 0;
      halted_m = 1'b0; wd_ok = 1'b1; idle = 0; deliv = 0;
      halt_cyc = (ep % 2 == 1) ? int'($urandom_range(250, 400)) : -1;
      for (int cyc = 0; cyc < 500 && wd_ok; cyc++) begin
        step();
        imem_req_ready = ($urandom_range(0, 3) != 0);
        inst_ready     = ($urandom_range(0, 1) != 0);
        halt           = (cyc == halt_cyc);
        redirect_valid = ($urandom_range(0, 15) == 0);
        redirect_pc    = rnd_target();
        if (pend && pend_cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_word(pend_addr);
          imem_resp_err   = mem_err(pend_addr[5:2]);
          pend            = 1'b0;
        end else begin
          imem_resp_valid = 1'b0;
          imem_resp_data  = $urandom;
          imem_resp_err   = 1'b0;
          if (pend) pend_cnt--;
        end
        smp();
        if (halted_m) begin
          n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_halted_req ep%0d cyc%0d: got %0b want 0", ep, cyc, imem_req_valid); end
          n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_halted_valid ep%0d cyc%0d: got %0b want 0", ep, cyc, inst_valid); end
        end else begin
          if (halt || redirect_valid) begin
            n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_suppress ep%0d cyc%0d: got %0b want 0", ep, cyc, imem_req_valid); end
          end
          if (imem_req_valid === 1'b1) begin
            n_checks++; if (imem_req_addr !== exp_pc) begin n_fail++; $display("FAIL rnd_req_addr ep%0d cyc%0d: got %h want %h", ep, cyc, imem_req_addr, exp_pc); end
            n_checks++; if (pend !== 1'b0) begin n_fail++; $display("FAIL rnd_outstanding ep%0d cyc%0d: got %0b want 0", ep, cyc, pend); end
            if (imem_req_ready) begin
              pend = 1'b1; pend_addr = imem_req_addr; pend_cnt = int'($urandom_range(0, 2));
            end
          end
          if (inst_valid === 1'b1) begin
            n_checks++; if (inst_pc !== exp_pc) begin n_fail++; $display("FAIL rnd_inst_pc ep%0d cyc%0d: got %h want %h", ep, cyc, inst_pc, exp_pc); end
            if (exp_pc[1:0] != 2'b00) begin
              n_checks++; if (inst !== 32'h0 || inst_fault !== 1'b1) begin n_fail++; $display("FAIL rnd_misaligned ep%0d cyc%0d: got %h/%0b want 0/1", ep, cyc, inst, inst_fault); end
            end else begin
              n_checks++; if (inst !== mem_word(exp_pc) || inst_fault !== mem_err(exp_pc[5:2])) begin n_fail++; $display("FAIL rnd_inst ep%0d cyc%0d: got %h/%0b want %h/%0b", ep, cyc, inst, inst_fault, mem_word(exp_pc), mem_err(exp_pc[5:2])); end
            end
          end
          if (imem_req_valid || inst_valid || redirect_valid || halt) idle = 0;
          else idle++;
          if (idle > 8) begin
            n_checks++; n_fail++; wd_ok = 1'b0;
            $display("FAIL rnd_watchdog ep%0d cyc%0d: got %0d idle cycles want <= 8", ep, cyc, idle);
          end
          if (halt) halted_m = 1'b1;
          else if (redirect_valid) exp_pc = redirect_pc;
          else if (inst_valid && inst_ready) begin
            exp_pc = exp_pc + 64'd4;
            deliv++;
          end
        end
      end
      n_checks++; if (deliv < 10) begin n_fail++; $display("FAIL rnd_progress ep%0d: got %0d deliveries want >= 10", ep, deliv); end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic_fetch();
    test_hold_stall();
    test_redirect_wait();
    test_misaligned();
    test_resp_err();
    test_halt_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit that produces the 32-bit instruction word and its PC for the decoder. It issues one instruction-memory read at a time and holds the returned word until the decode stage accepts it. It steers the PC from reset, sequential +4, redirect (jal/jalr/taken branch) and halt (ebreak). It sits between the instruction-memory port and the decoder's `inst` input.

## Interface
- `RESET_PC`, 64'h8000_0000, first fetch address after reset.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `redirect_valid`  in  1  replace the PC with `redirect_pc` (jal/jalr/taken branch).
- `redirect_pc`  in  64  redirect target.
- `halt`  in  1  ebreak retired; stop fetching permanently until reset.
- `imem_req_valid`  out  1  read request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  64  read address; always equals the internal PC.
- `imem_resp_valid`  in  1  read data valid; one response per accepted request, at least 1 cycle after acceptance.
- `imem_resp_data`  in  32  instruction word.
- `imem_resp_err`  in  1  access fault for this response.
- `inst_valid`  out  1  instruction available to decoder.
- `inst_ready`  in  1  decoder consumes instruction.
- `inst`  out  32  instruction word.
- `inst_pc`  out  64  PC of `inst`.
- `inst_fault`  out  1  fetch fault (misaligned PC or memory error).

## Operation
- States: REQ, WAIT, DRAIN, HOLD, HALTED. Reset: state REQ, pc=RESET_PC, `inst_valid`=0, `inst`=0, `inst_pc`=0, `inst_fault`=0.
- `imem_req_valid` = (state==REQ) & ~redirect_valid & ~halt & (pc[1:0]==0). The address is `pc`.
- REQ:
  - halt → HALTED.
  - Else redirect → pc<=redirect_pc, stay REQ.
  - Else if pc[1:0]!=0 → load `inst`=0, `inst_pc`=pc, `inst_fault`=1, go HOLD. No memory request is issued.
  - Else on req handshake → WAIT.
- WAIT:
  - halt → DRAIN, then HALTED after the response.
  - redirect without resp → pc<=redirect_pc, DRAIN.
  - redirect with resp → response discarded, pc<=redirect_pc, REQ.
  - resp alone → `inst`=data, `inst_pc`=pc, `inst_fault`=resp_err, HOLD.
- DRAIN:
  - Wait for the response and discard it, then go to REQ, or to HALTED if halt was seen.
  - A redirect in DRAIN updates pc and stays in DRAIN.
- HOLD:
  - `inst_valid`=1.
  - halt → HALTED.
  - Else redirect → drop the instruction, pc<=redirect_pc, REQ.
  - Else on `inst_valid & inst_ready` → pc<=pc+4, REQ.
- HALTED: no requests, `inst_valid`=0. Responses are ignored. Only reset exits.
- Priority every cycle: halt > redirect > normal progress.
- `imem_resp_valid` outside WAIT/DRAIN is ignored.
- pc+4 wraps modulo 2^64. A misaligned pc can arise only from a redirect or a misaligned RESET_PC.
- `inst`/`inst_pc`/`inst_fault` are stable while `inst_valid`=1 and not consumed.

## Timing
- Request accepted at edge N. Response at N+k (k≥1). `inst_valid` is registered high at N+k+1.
- Consumption at edge M gives `imem_req_valid` high in cycle M+1 with addr=pc+4.
- Best-case throughput is 1 instruction per 3 cycles. Only one request is outstanding at a time.
- Redirect takes effect on the next edge. `imem_req_valid` is suppressed combinationally in the redirect cycle.
- Async reset mid-operation clears all state immediately. An in-flight response arriving after reset deasserts falls in REQ and is ignored.

## Test plan
- Reset release, ready=1, response 1 cycle later data 32'h00100093 → req addr 0x8000_0000. `inst_valid` at cycle 3 with inst_pc=0x8000_0000 and fault=0. After consume, next req addr 0x8000_0004.
- Hold `inst_ready`=0 for 5 cycles in HOLD → inst/inst_pc unchanged and `imem_req_valid`=0 throughout. Consume → pc+4 fetched.
- Redirect to 0x8000_0100 in WAIT, response 2 cycles later data 32'hDEADBEEF → that word never appears. Next req addr 0x8000_0100 in the cycle after the response.
- Redirect to 0x8000_0102 → no memory request. `inst_valid` with inst=0, inst_pc=0x8000_0102, fault=1.
- Response with `imem_resp_err`=1, data 32'h0 → `inst_fault`=1, inst_pc equals the request address.
- Halt in WAIT → response consumed, no further `imem_req_valid`. Then assert rst_n low mid-cycle → outputs clear immediately. After release, req addr=RESET_PC.
